hazard_tracker: RTL and testbench

- Producer side of the pipeline hazard handshake.
- Carries register-address tags and valid/PC-write bits from Decode through Execute, Memory and Writeback, and applies the hazard unit's StallD/FlushD/FlushE to those tags.
- Generates the Match_* compare flags and PCWrPendingF that the hazard unit consumes.
- Sits beside the datapath pipeline registers: one instance per core, fed by the decoder.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_tracker_if.sv | 41 ++++
 rtl/hazard_stage_reg.sv | 36 +++
 rtl/hazard_tracker.sv | 129 ++++++++++++
 tb/tb_hazard_tracker.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and encodings for the pipeline hazard tracker.
// Build option: HAZ_TRACK_R15_FILTER_EN makes R15 source compares never match.
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 4;
  localparam logic [3:0] R15 = 4'hF;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // R15 reads take the PC+8 path, so forwarding to them is never needed.
`ifdef HAZ_TRACK_R15_FILTER_EN
  localparam bit R15_FILTER = 1'b1;
`else
  localparam bit R15_FILTER = 1'b0;
`endif

endpackage

// File: rtl/hazard_tracker_if.sv
// Handshake bundle between the decoder/hazard unit (master) and the tracker (slave).
interface hazard_tracker_if #(
  parameter int REG_AW = hazard_pkg::REG_AW_DEFAULT,
  parameter int CNT_W  = 16
);
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic              InstrFetchedF;
  logic [REG_AW-1:0] RA1D;
  logic [REG_AW-1:0] RA2D;
  logic [REG_AW-1:0] RA3D;
  logic [REG_AW-1:0] WA3D;
  logic              RegWriteD;
  logic              PCSrcD;
  logic              Match_1E_M;
  logic              Match_1E_W;
  logic              Match_2E_M;
  logic              Match_2E_W;
  logic              Match_3E_M;
  logic              Match_3E_W;
  logic              Match_12D_E;
  logic              PCWrPendingF;
  logic              PCSrcW;
  logic [CNT_W-1:0]  LdStallCnt;

  modport master (
    output StallD, FlushD, FlushE, InstrFetchedF,
    output RA1D, RA2D, RA3D, WA3D, RegWriteD, PCSrcD,
    input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_3E_M, Match_3E_W,
    input  Match_12D_E, PCWrPendingF, PCSrcW, LdStallCnt
  );

  modport slave (
    input  StallD, FlushD, FlushE, InstrFetchedF,
    input  RA1D, RA2D, RA3D, WA3D, RegWriteD, PCSrcD,
    output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_3E_M, Match_3E_W,
    output Match_12D_E, PCWrPendingF, PCSrcW, LdStallCnt
  );

endinterface

// File: rtl/hazard_stage_reg.sv
// One pipeline stage of valid/tag state: enable holds, clear zeroes only the
// CLR_MASK bits (valid/control) and leaves address tags as they were.
module hazard_stage_reg #(
  parameter int             W        = 1,
  parameter logic [W-1:0]   CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q, stage_d;

  // NOTE: every path of a combinational block must assign its outputs; the
  // default-first assignment below prevents an inferred latch.
  always_comb begin
    stage_d = stage_q;
    if (en_i) begin
      if (clr_i) stage_d = stage_q & ~CLR_MASK;
      else       stage_d = d_i;
    end
  end

  // NOTE: state flops use non-blocking assignments so all stages update
  // together on the edge regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign q_o = stage_q;

endmodule

// File: rtl/hazard_tracker.sv
// Producer side of the hazard handshake: carries D/E/M/W valid and register tags
// and produces the match flags, PC-write status and load-stall counter.
// Build option: HAZ_TRACK_R15_FILTER_EN (see hazard_pkg).
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  hazard_tracker_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              pcsrc;
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic [REG_AW-1:0] ra3;
    logic [REG_AW-1:0] wa3;
  } ex_stage_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              pcsrc;
    logic [REG_AW-1:0] wa3;
  } mw_stage_t;

  localparam ex_stage_t EX_CLR_MASK = '{valid: 1'b1, regwrite: 1'b1, pcsrc: 1'b1, default: '0};

  logic      dec_valid_q;
  ex_stage_t ex_d, ex_q;
  mw_stage_t mem_d, mem_q, wb_q;
  logic [CNT_W-1:0] ld_stall_cnt_q, ld_stall_cnt_d;

  function automatic logic src_hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
    return (src == dst) && !(R15_FILTER && (src == REG_AW'(R15)));
  endfunction

  // StallD wins over FlushD because a disabled stage ignores its clear.
  hazard_stage_reg #(.W(1), .CLR_MASK(1'b1)) u_dec (
    .clk   (clk),
    .reset (reset),
    .en_i  (~bus.StallD),
    .clr_i (bus.FlushD),
    .d_i   (bus.InstrFetchedF),
    .q_o   (dec_valid_q)
  );

  always_comb begin
    ex_d          = '0;
    ex_d.valid    = dec_valid_q;
    ex_d.regwrite = bus.RegWriteD & dec_valid_q;
    ex_d.pcsrc    = bus.PCSrcD & dec_valid_q;
    ex_d.ra1      = bus.RA1D;
    ex_d.ra2      = bus.RA2D;
    ex_d.ra3      = bus.RA3D;
    ex_d.wa3      = bus.WA3D;
  end

  hazard_stage_reg #(.W($bits(ex_stage_t)), .CLR_MASK(EX_CLR_MASK)) u_ex (
    .clk   (clk),
    .reset (reset),
    .en_i  (1'b1),
    .clr_i (bus.FlushE),
    .d_i   (ex_d),
    .q_o   (ex_q)
  );

  always_comb begin
    mem_d          = '0;
    mem_d.valid    = ex_q.valid;
    mem_d.regwrite = ex_q.regwrite;
    mem_d.pcsrc    = ex_q.pcsrc;
    mem_d.wa3      = ex_q.wa3;
  end

  hazard_stage_reg #(.W($bits(mw_stage_t))) u_mem (
    .clk   (clk),
    .reset (reset),
    .en_i  (1'b1),
    .clr_i (1'b0),
    .d_i   (mem_d),
    .q_o   (mem_q)
  );

  hazard_stage_reg #(.W($bits(mw_stage_t))) u_wb (
    .clk   (clk),
    .reset (reset),
    .en_i  (1'b1),
    .clr_i (1'b0),
    .d_i   (mem_q),
    .q_o   (wb_q)
  );

  // Pure address compares; the hazard unit qualifies them with RegWriteM/W.
  assign bus.Match_1E_M  = ex_q.valid & mem_q.valid & src_hit(ex_q.ra1, mem_q.wa3);
  assign bus.Match_1E_W  = ex_q.valid & wb_q.valid  & src_hit(ex_q.ra1, wb_q.wa3);
  assign bus.Match_2E_M  = ex_q.valid & mem_q.valid & src_hit(ex_q.ra2, mem_q.wa3);
  assign bus.Match_2E_W  = ex_q.valid & wb_q.valid  & src_hit(ex_q.ra2, wb_q.wa3);
  assign bus.Match_3E_M  = ex_q.valid & mem_q.valid & src_hit(ex_q.ra3, mem_q.wa3);
  assign bus.Match_3E_W  = ex_q.valid & wb_q.valid  & src_hit(ex_q.ra3, wb_q.wa3);
  assign bus.Match_12D_E = dec_valid_q & ex_q.valid &
                           (src_hit(bus.RA1D, ex_q.wa3) | src_hit(bus.RA2D, ex_q.wa3));

  assign bus.PCWrPendingF = (bus.PCSrcD & dec_valid_q) | ex_q.pcsrc | mem_q.pcsrc;
  assign bus.PCSrcW       = wb_q.pcsrc;

  always_comb begin
    ld_stall_cnt_d = ld_stall_cnt_q;
    if (bus.StallD && bus.FlushE && (ld_stall_cnt_q != '1))
      ld_stall_cnt_d = ld_stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ld_stall_cnt_q <= '0;
    else       ld_stall_cnt_q <= ld_stall_cnt_d;
  end

  assign bus.LdStallCnt = ld_stall_cnt_q;

  // W-stage RegWrite is carried for completeness but consumed outside this block.
  logic unused_wb_regwrite;
  assign unused_wb_regwrite = wb_q.regwrite;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed-vector bench for hazard_tracker; a second 4-bit-counter instance
// exercises counter saturation.
module tb_hazard_tracker;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hazard_tracker_if #(.REG_AW(4), .CNT_W(16)) bus ();
  hazard_tracker_if #(.REG_AW(4), .CNT_W(4))  bus4 ();

  hazard_tracker #(.REG_AW(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  hazard_tracker #(.REG_AW(4), .CNT_W(4)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output vector bit positions.
  localparam logic [8:0] B_1EM  = 9'h100;
  localparam logic [8:0] B_1EW  = 9'h080;
  localparam logic [8:0] B_2EM  = 9'h040;
  localparam logic [8:0] B_2EW  = 9'h020;
  localparam logic [8:0] B_3EM  = 9'h010;
  localparam logic [8:0] B_3EW  = 9'h008;
  localparam logic [8:0] B_12D  = 9'h004;
  localparam logic [8:0] B_PCWR = 9'h002;
  localparam logic [8:0] B_PCSW = 9'h001;

`ifdef HAZ_TRACK_R15_FILTER_EN
  localparam bit R15_HIT = 1'b0;
`else
  localparam bit R15_HIT = 1'b1;
`endif

  function automatic logic [8:0] outs();
    return {bus.Match_1E_M, bus.Match_1E_W, bus.Match_2E_M, bus.Match_2E_W,
            bus.Match_3E_M, bus.Match_3E_W, bus.Match_12D_E, bus.PCWrPendingF, bus.PCSrcW};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] ra3,
                       input logic [3:0] wa3, input logic rw, input logic pcsrc, input logic fetch);
    bus.RA1D = ra1; bus.RA2D = ra2; bus.RA3D = ra3; bus.WA3D = wa3;
    bus.RegWriteD = rw; bus.PCSrcD = pcsrc; bus.InstrFetchedF = fetch;
  endtask

  task automatic idle();
    bus.StallD = 1'b0; bus.FlushD = 1'b0; bus.FlushE = 1'b0;
    set_d(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    idle();
    bus4.StallD = 1'b0; bus4.FlushD = 1'b0; bus4.FlushE = 1'b0; bus4.InstrFetchedF = 1'b0;
    bus4.RA1D = '0; bus4.RA2D = '0; bus4.RA3D = '0; bus4.WA3D = '0;
    bus4.RegWriteD = 1'b0; bus4.PCSrcD = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    tick();
    #1;
    obs = outs();
    checks++; if (obs !== 9'h000) begin failures++; $display("FAIL reset_outs got=%b exp=%b", obs, 9'h000); end
    checks++; if (bus.LdStallCnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.LdStallCnt); end
    tick();
    reset = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [8:0] obs;
    set_d(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1); tick();
    set_d(4'h1, 4'h2, 4'h0, 4'h3, 1'b1, 1'b0, 1'b1); #1;         // ADD r3
    obs = outs();
    checks++; if (obs !== 9'h000) begin failures++; $display("FAIL b2b_c0 got=%b exp=%b", obs, 9'h000); end
    tick();
    set_d(4'h3, 4'h4, 4'h5, 4'h7, 1'b1, 1'b0, 1'b1); #1;         // SUB reads r3
    obs = outs();
    checks++; if (obs !== B_12D) begin failures++; $display("FAIL b2b_c1 got=%b exp=%b", obs, B_12D); end
    tick();
    set_d(4'h3, 4'h8, 4'h9, 4'hA, 1'b1, 1'b0, 1'b0); #1;         // AND reads r3
    obs = outs();
    checks++; if (obs !== B_1EM) begin failures++; $display("FAIL b2b_c2 got=%b exp=%b", obs, B_1EM); end
    tick();
    idle(); #1;
    obs = outs();
    checks++; if (obs !== B_1EW) begin failures++; $display("FAIL b2b_c3 got=%b exp=%b", obs, B_1EW); end
    tick(); #1;
    obs = outs();
    checks++; if (obs !== 9'h000) begin failures++; $display("FAIL b2b_c4 got=%b exp=%b", obs, 9'h000); end
    drain();
  endtask

  task automatic test_load_use();
    logic [8:0] obs;
    set_d(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1); tick();
    set_d(4'h1, 4'h2, 4'h0, 4'h5, 1'b1, 1'b0, 1'b1); tick();     // LDR r5
    set_d(4'h6, 4'h5, 4'h0, 4'h9, 1'b1, 1'b0, 1'b1);             // user of r5
    bus.StallD = 1'b1; bus.FlushE = 1'b1; #1;
    obs = outs();
    checks++; if (obs !== B_12D) begin failures++; $display("FAIL ldu_stall got=%b exp=%b", obs, B_12D); end
    checks++; if (bus.LdStallCnt !== 16'd0) begin failures++; $display("FAIL ldu_cnt0 got=%0d exp=0", bus.LdStallCnt); end
    tick();
    bus.StallD = 1'b0; bus.FlushE = 1'b0; bus.InstrFetchedF = 1'b0; #1;
    obs = outs();
    checks++; if (obs !== 9'h000) begin failures++; $display("FAIL ldu_bubble got=%b exp=%b", obs, 9'h000); end
    checks++; if (bus.LdStallCnt !== 16'd1) begin failures++; $display("FAIL ldu_cnt1 got=%0d exp=1", bus.LdStallCnt); end
    tick();
    idle(); #1;
    obs = outs();
    checks++; if (obs !== B_2EW) begin failures++; $display("FAIL ldu_fwd got=%b exp=%b", obs, B_2EW); end
    drain();
  endtask

  task automatic test_branch();
    logic [8:0] obs;
    set_d(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1); tick();
    set_d(4'h1, 4'h2, 4'h3, 4'h0, 1'b0, 1'b1, 1'b1); #1;         // branch in D
    obs = outs();
    checks++; if (obs !== B_PCWR) begin failures++; $display("FAIL br_d got=%b exp=%b", obs, B_PCWR); end
    tick();
    set_d(4'h1, 4'h2, 4'h3, 4'h0, 1'b0, 1'b0, 1'b1);
    bus.FlushD = 1'b1; #1;
    obs = outs();
    checks++; if (obs !== B_PCWR) begin failures++; $display("FAIL br_e got=%b exp=%b", obs, B_PCWR); end
    tick();
    bus.FlushD = 1'b0;
    set_d(4'h1, 4'h2, 4'h3, 4'h0, 1'b0, 1'b1, 1'b0); #1;
    obs = outs();
    checks++; if (obs !== B_PCWR) begin failures++; $display("FAIL br_m got=%b exp=%b", obs, B_PCWR); end
    tick(); #1;
    obs = outs();
    checks++; if (obs !== B_PCSW) begin failures++; $display("FAIL br_w_flushd got=%b exp=%b", obs, B_PCSW); end
    tick();
    idle(); #1;
    obs = outs();
    checks++; if (obs !== 9'h000) begin failures++; $display("FAIL br_done got=%b exp=%b", obs, 9'h000); end
    drain();
  endtask

  task automatic test_stall_priority();
    logic [8:0] obs;
    set_d(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1); tick();
    set_d(4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 1'b0, 1'b0);
    bus.StallD = 1'b1; bus.FlushD = 1'b1; bus.FlushE = 1'b1;
    tick();
    bus.StallD = 1'b0; bus.FlushD = 1'b0; bus.FlushE = 1'b0;
    bus.PCSrcD = 1'b1; #1;
    obs = outs();
    checks++; if (obs !== B_PCWR) begin failures++; $display("FAIL prio_validd got=%b exp=%b", obs, B_PCWR); end
    checks++; if (bus.LdStallCnt !== 16'd2) begin failures++; $display("FAIL prio_cnt got=%0d exp=2", bus.LdStallCnt); end
    tick();
    drain();
  endtask

  task automatic test_r15();
    logic [8:0] obs;
    logic [8:0] exp;
    set_d(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1); tick();
    set_d(4'h1, 4'h2, 4'h3, 4'hF, 1'b1, 1'b0, 1'b1); tick();     // writes r15
    set_d(4'hF, 4'h2, 4'h3, 4'h1, 1'b1, 1'b0, 1'b1); #1;
    obs = outs(); exp = R15_HIT ? B_12D : 9'h000;
    checks++; if (obs !== exp) begin failures++; $display("FAIL r15_d_e got=%b exp=%b", obs, exp); end
    tick();
    set_d(4'hF, 4'h2, 4'h3, 4'h6, 1'b1, 1'b0, 1'b0); #1;
    obs = outs(); exp = R15_HIT ? B_1EM : 9'h000;
    checks++; if (obs !== exp) begin failures++; $display("FAIL r15_e_m got=%b exp=%b", obs, exp); end
    tick();
    idle(); #1;
    obs = outs(); exp = R15_HIT ? B_1EW : 9'h000;
    checks++; if (obs !== exp) begin failures++; $display("FAIL r15_e_w got=%b exp=%b", obs, exp); end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [8:0] obs;
    set_d(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1); tick();
    set_d(4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b0, 1'b1); tick();     // writes r4
    set_d(4'h5, 4'h6, 4'h4, 4'h7, 1'b1, 1'b0, 1'b1); tick();     // reads r4 as Rs
    set_d(4'h8, 4'h9, 4'hA, 4'hB, 1'b0, 1'b1, 1'b1); #1;
    obs = outs();
    checks++; if (obs !== (B_3EM | B_PCWR)) begin failures++; $display("FAIL rstmid_pre got=%b exp=%b", obs, B_3EM | B_PCWR); end
    #1 reset = 1'b1;
    #1;
    obs = outs();
    checks++; if (obs !== 9'h000) begin failures++; $display("FAIL rstmid_async got=%b exp=%b", obs, 9'h000); end
    checks++; if (bus.LdStallCnt !== 16'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", bus.LdStallCnt); end
    tick();
    reset = 1'b0;
    drain();
  endtask

  task automatic test_saturation();
    bus4.StallD = 1'b1; bus4.FlushE = 1'b1;
    repeat (14) tick();
    checks++; if (bus4.LdStallCnt !== 4'd14) begin failures++; $display("FAIL sat_14 got=%0d exp=14", bus4.LdStallCnt); end
    tick();
    checks++; if (bus4.LdStallCnt !== 4'hF) begin failures++; $display("FAIL sat_max got=%0d exp=15", bus4.LdStallCnt); end
    repeat (5) tick();
    checks++; if (bus4.LdStallCnt !== 4'hF) begin failures++; $display("FAIL sat_hold got=%0d exp=15", bus4.LdStallCnt); end
    bus4.StallD = 1'b0; bus4.FlushE = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_stall_priority();
    test_r15();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
